// File: rtl/ac_pkg.sv
// Shared types and helpers for the multi-zone air-conditioning controller.
package ac_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    HEATING = 2'b01,
    COOLING = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    MODE_OFF       = 2'b00,
    MODE_AUTO      = 2'b01,
    MODE_HEAT_ONLY = 2'b10,
    MODE_COOL_ONLY = 2'b11
  } mode_e;

  // Dwell counter must hold max(MIN_ON, MIN_OFF).
  function automatic int dwell_w(input int min_on, input int min_off);
    int m;
    m = (min_on > min_off) ? min_on : min_off;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ac_zone_fsm.sv
// One zone: heat/idle/cool hysteresis FSM with anti-short-cycle dwell timing.
module ac_zone_fsm
  import ac_pkg::*;
#(
  parameter int TW       = 5,
  parameter int HEAT_ON  = 18,
  parameter int HEAT_OFF = 20,
  parameter int COOL_ON  = 22,
  parameter int COOL_OFF = 20,
  parameter int MIN_ON   = 4,
  parameter int MIN_OFF  = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [TW-1:0] temp,
  input  logic [1:0]    mode,
  input  logic          en,
  output logic          heating,
  output logic          cooling
);

  localparam int DMAX = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
  localparam int DW   = dwell_w(MIN_ON, MIN_OFF);

  localparam logic [TW-1:0] T_HEAT_ON  = TW'(HEAT_ON);
  localparam logic [TW-1:0] T_HEAT_OFF = TW'(HEAT_OFF);
  localparam logic [TW-1:0] T_COOL_ON  = TW'(COOL_ON);
  localparam logic [TW-1:0] T_COOL_OFF = TW'(COOL_OFF);

  state_e        state, nxt;
  logic [DW-1:0] cnt;
  logic          fresh;
  logic          force_idle, dwell_ok, heat_ok, cool_ok;
  mode_e         md;

  assign md      = mode_e'(mode);
  assign heat_ok = (md == MODE_AUTO) || (md == MODE_HEAT_ONLY);
  assign cool_ok = (md == MODE_AUTO) || (md == MODE_COOL_ONLY);

  always_comb begin
    force_idle = (md == MODE_OFF) || !en ||
                 (state == COOLING && md == MODE_HEAT_ONLY) ||
                 (state == HEATING && md == MODE_COOL_ONLY);
    // fresh lets a zone fire on the first edge after reset without the off-gap
    if (state == IDLE) dwell_ok = fresh || (cnt >= DW'(MIN_OFF - 1));
    else               dwell_ok = (cnt >= DW'(MIN_ON - 1));
    nxt = state;
    case (state)
      IDLE: begin
        if (!force_idle && dwell_ok) begin
          if (temp <= T_HEAT_ON && heat_ok)      nxt = HEATING;
          else if (temp >= T_COOL_ON && cool_ok) nxt = COOLING;
        end
      end
      HEATING: if (force_idle || (temp >= T_HEAT_OFF && dwell_ok)) nxt = IDLE;
      COOLING: if (force_idle || (temp <= T_COOL_OFF && dwell_ok)) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      fresh   <= 1'b1;
      heating <= 1'b0;
      cooling <= 1'b0;
    end else begin
      state   <= nxt;
      heating <= (nxt == HEATING);
      cooling <= (nxt == COOLING);
      if (nxt != state) begin
        cnt   <= '0;
        fresh <= 1'b0;
      end else if (cnt != DW'(DMAX)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ac_multizone.sv
// N_ZONES independent air-conditioning zone controllers with a shared mode.
module ac_multizone
  import ac_pkg::*;
#(
  parameter int N_ZONES  = 2,
  parameter int TW       = 5,
  parameter int HEAT_ON  = 18,
  parameter int HEAT_OFF = 20,
  parameter int COOL_ON  = 22,
  parameter int COOL_OFF = 20,
  parameter int MIN_ON   = 4,
  parameter int MIN_OFF  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_ZONES*TW-1:0] temperature,
  input  logic [1:0]            mode,
  input  logic [N_ZONES-1:0]    zone_en,
  output logic [N_ZONES-1:0]    heating,
  output logic [N_ZONES-1:0]    cooling,
  output logic                  any_active
);

  // Threshold ordering keeps heat/cool entry conditions disjoint.
  if (!(N_ZONES >= 1 && MIN_ON >= 1 && MIN_OFF >= 1 &&
        HEAT_ON < HEAT_OFF && HEAT_OFF <= COOL_OFF + 1 && COOL_OFF < COOL_ON &&
        HEAT_ON >= 0 && COOL_ON < (1 << TW))) begin : g_bad_params
    $error("ac_multizone: illegal parameter set");
  end

  for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
    ac_zone_fsm #(
      .TW(TW), .HEAT_ON(HEAT_ON), .HEAT_OFF(HEAT_OFF),
      .COOL_ON(COOL_ON), .COOL_OFF(COOL_OFF),
      .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF)
    ) u_zone (
      .clk    (clk),
      .rst_n  (rst_n),
      .temp   (temperature[z*TW +: TW]),
      .mode   (mode),
      .en     (zone_en[z]),
      .heating(heating[z]),
      .cooling(cooling[z])
    );
  end

  assign any_active = |{heating, cooling};

endmodule

// File: tb/tb_ac_multizone.sv
// Directed-vector bench for ac_multizone at N_ZONES=2, TW=5, default thresholds.
module tb_ac_multizone;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] t0, t1;
  logic [1:0] mode;
  logic [1:0] zone_en;
  logic [1:0] heating, cooling;
  logic       any_active;

  int checks = 0;
  int errors = 0;

  ac_multizone #(.N_ZONES(2), .TW(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .temperature({t1, t0}),
    .mode       (mode),
    .zone_en    (zone_en),
    .heating    (heating),
    .cooling    (cooling),
    .any_active (any_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'b01; zone_en = 2'b11; t0 = 5'd10; t1 = 5'd20;

    // reset held 3 cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_heat", heating, 2'b00);
      chk("rst_cool", cooling, 2'b00);
      chk("rst_any", any_active, 1'b0);
    end
    rst_n = 1'b1;
    step();
    chk("rel_heat", heating, 2'b01);
    chk("rel_any", any_active, 1'b1);

    // min-on / min-off
    t0 = 5'd20; do_reset();
    t0 = 5'd18; step();
    chk("mo_rise", heating, 2'b01);
    t0 = 5'd25;
    for (int i = 0; i < 3; i++) begin
      step(); chk("mo_on", heating, 2'b01);
    end
    for (int i = 0; i < 3; i++) begin
      step(); chk("mo_gap_h", heating, 2'b00); chk("mo_gap_c", cooling, 2'b00);
    end
    step();
    chk("mo_cool", cooling, 2'b01);

    // hysteresis
    t0 = 5'd21;
    for (int i = 0; i < 4; i++) step();
    chk("hy_cool_hold", cooling, 2'b01);
    t0 = 5'd20; step();
    chk("hy_cool_off", cooling, 2'b00);
    t0 = 5'd19;
    for (int i = 0; i < 4; i++) step();
    chk("hy_idle19", {heating, cooling}, 4'b0000);
    t0 = 5'd21; step();
    chk("hy_idle21", {heating, cooling}, 4'b0000);
    t0 = 5'd18; step();
    chk("hy_heat_on", heating, 2'b01);
    t0 = 5'd19;
    for (int i = 0; i < 4; i++) step();
    chk("hy_heat_hold", heating, 2'b01);
    t0 = 5'd20; step();
    chk("hy_heat_off", heating, 2'b00);

    // mode / enable override
    t0 = 5'd20; t1 = 5'd23; do_reset();
    step();
    chk("ov_cool", cooling, 2'b10);
    step();
    mode = 2'b10; step();
    chk("ov_heatonly", cooling, 2'b00);
    t1 = 5'd15;
    step(); chk("ov_gap1", heating, 2'b00);
    step(); chk("ov_gap2", heating, 2'b00);
    step(); chk("ov_heat", heating, 2'b10);
    mode = 2'b00; step();
    chk("ov_off", heating, 2'b00);
    mode = 2'b01;
    for (int i = 0; i < 3; i++) step();
    chk("ov_reheat", heating, 2'b10);
    zone_en = 2'b01; step();
    chk("ov_en", heating, 2'b00);
    chk("ov_en_any", any_active, 1'b0);

    // zone independence
    zone_en = 2'b11; t0 = 5'd20; t1 = 5'd20; do_reset();
    t0 = 5'd18; t1 = 5'd22; step();
    chk("ind_heat", heating, 2'b01);
    chk("ind_cool", cooling, 2'b10);
    chk("ind_any", any_active, 1'b1);

    // reset during heating dwell
    t0 = 5'd5; step();
    rst_n = 1'b0; step();
    chk("mr_heat", heating, 2'b00);
    chk("mr_cool", cooling, 2'b00);
    chk("mr_any", any_active, 1'b0);
    rst_n = 1'b1; step();
    chk("mr_rel_heat", heating, 2'b01);
    chk("mr_rel_cool", cooling, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
